// File: rtl/pc_gen.sv
// Fetch-side program counter with boot delay, redirect, trap entry and trap return.
// Optional PC_MISALIGN_TRAP_EN turns misaligned redirects into traps.
module pc_gen #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int               ILEN_BYTES   = 4,
  parameter int               BOOT_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic            trap_ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_o
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int SH = $clog2(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(ILEN_BYTES - 1);
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   boot_cnt;
  logic [XLEN-1:0] redir_aligned;

  assign pc_plus_o     = pc_o + XLEN'(ILEN_BYTES);
  assign pc_valid_o    = (state == RUN);
  assign redir_aligned = redirect_pc_i & ALIGN_MASK;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;
  logic redir_mis;

  assign redir_mis  = redirect_pc_i[SH-1:0] != '0;
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc_o     <= RESET_VECTOR;
      epc_o    <= '0;
      boot_cnt <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      unique case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 1'b1;
          if (boot_cnt == BOOT_LAST)
            state <= RUN;
        end
        RUN: begin
          if (trap_i) begin
            epc_o <= pc_o;
            pc_o  <= TRAP_VECTOR;
          end else if (trap_ret_i) begin
            pc_o <= epc_o;
          end else if (redirect_i) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (redir_mis) begin
              epc_o      <= redirect_pc_i;
              pc_o       <= TRAP_VECTOR;
              misalign_q <= 1'b1;
            end else begin
              pc_o <= redir_aligned;
            end
`else
            pc_o <= redir_aligned;
`endif
          end else if (fetch_ready_i && !stall_i) begin
            pc_o <= pc_plus_o;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot delay, sequencing, redirect, traps, wrap.
// Expected values are hand-computed for the default parameters.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_ready_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        trap_i;
  logic        trap_ret_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        pc_valid_o;
  logic [31:0] epc_o;
  logic        misalign_o;

  int vectors = 0;
  int miscompares = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_ready_i (fetch_ready_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .trap_ret_i    (trap_ret_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .pc_valid_o    (pc_valid_o),
    .epc_o         (epc_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_ready_i = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    trap_i        = 1'b0;
    trap_ret_i    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    fetch_ready_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (pc_valid_o !== 1'b0 || pc_o !== 32'h0 || epc_o !== 32'h0
        || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b pc=%h epc=%h mis=%b, want 0 0 0 0",
               pc_valid_o, pc_o, epc_o, misalign_o);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      vectors++;
      if (pc_valid_o !== 1'b0 || pc_o !== 32'h0) begin
        miscompares++;
        $display("FAIL boot_cycle%0d: got valid=%b pc=%h, want 0 00000000",
                 i, pc_valid_o, pc_o);
      end
    end
    tick();
    vectors++;
    if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL boot_done: got valid=%b pc=%h, want 1 00000000",
               pc_valid_o, pc_o);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (pc_o !== 32'(4 * i) || pc_valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_adv%0d: got pc=%h valid=%b, want %h 1",
                 i, pc_o, pc_valid_o, 32'(4 * i));
      end
    end
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc_o !== 32'hC || pc_plus_o !== 32'h10) begin
        miscompares++;
        $display("FAIL seq_hold%0d: got pc=%h plus=%h, want 0000000c 00000010",
                 i, pc_o, pc_plus_o);
      end
    end
    fetch_ready_i = 1'b1;
    stall_i = 1'b1;
    tick();
    vectors++;
    if (pc_o !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_hold: got pc=%h, want 0000000c", pc_o);
    end
    clear_inputs();
  endtask

  task automatic test_redirect_trap();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    stall_i = 1'b1;
    tick();
    vectors++;
    if (pc_o !== 32'h200) begin
      miscompares++;
      $display("FAIL redirect_stall: got pc=%h, want 00000200", pc_o);
    end
    redirect_pc_i = 32'h300;
    trap_i = 1'b1;
    tick();
    vectors++;
    if (pc_o !== 32'h100 || epc_o !== 32'h200) begin
      miscompares++;
      $display("FAIL trap_over_redirect: got pc=%h epc=%h, want 00000100 00000200",
               pc_o, epc_o);
    end
    clear_inputs();
  endtask

  task automatic test_trap_return();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    trap_i = 1'b1;
    tick();
    vectors++;
    if (pc_o !== 32'h100 || epc_o !== 32'h40) begin
      miscompares++;
      $display("FAIL trap_entry: got pc=%h epc=%h, want 00000100 00000040",
               pc_o, epc_o);
    end
    trap_i = 1'b0;
    fetch_ready_i = 1'b1;
    tick();
    tick();
    vectors++;
    if (pc_o !== 32'h108) begin
      miscompares++;
      $display("FAIL trap_handler_adv: got pc=%h, want 00000108", pc_o);
    end
    trap_ret_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    tick();
    vectors++;
    if (pc_o !== 32'h40 || epc_o !== 32'h40) begin
      miscompares++;
      $display("FAIL trap_return: got pc=%h epc=%h, want 00000040 00000040",
               pc_o, epc_o);
    end
    clear_inputs();
  endtask

  task automatic test_wrap_and_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    vectors++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus_o !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_top: got pc=%h plus=%h, want fffffffc 00000000",
               pc_o, pc_plus_o);
    end
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    vectors++;
    if (pc_o !== 32'h0 || pc_plus_o !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_adv: got pc=%h plus=%h, want 00000000 00000004",
               pc_o, pc_plus_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h500;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (pc_valid_o !== 1'b0 || pc_o !== 32'h0 || epc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_run_reset: got valid=%b pc=%h epc=%h, want 0 0 0",
               pc_valid_o, pc_o, epc_o);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (pc_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reboot_last: got valid=%b, want 0", pc_valid_o);
    end
    tick();
    vectors++;
    if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reboot_done: got valid=%b pc=%h, want 1 00000000",
               pc_valid_o, pc_o);
    end
  endtask

  task automatic test_misalign();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h202;
    tick();
    clear_inputs();
`ifdef PC_MISALIGN_TRAP_EN
    vectors++;
    if (pc_o !== 32'h100 || epc_o !== 32'h202 || misalign_o !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_trap: got pc=%h epc=%h mis=%b, want 00000100 00000202 1",
               pc_o, epc_o, misalign_o);
    end
    tick();
    vectors++;
    if (misalign_o !== 1'b0 || pc_o !== 32'h100) begin
      miscompares++;
      $display("FAIL misalign_pulse: got mis=%b pc=%h, want 0 00000100",
               misalign_o, pc_o);
    end
`else
    vectors++;
    if (pc_o !== 32'h200 || epc_o !== 32'h0 || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_mask: got pc=%h epc=%h mis=%b, want 00000200 0 0",
               pc_o, epc_o, misalign_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h317;
    tick();
    clear_inputs();
    vectors++;
    if (pc_o !== 32'h314 || misalign_o !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_mask2: got pc=%h mis=%b, want 00000314 0",
               pc_o, misalign_o);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_redirect_trap();
    test_trap_return();
    test_wrap_and_reset();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
